// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage pipeline
// (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Arbitrates, in priority order, a memory-stage exception flush, a
// multi-cycle EX operation (sequenced by an IDLE/MC_BUSY down-counter FSM)
// and a decode load-use stall. Outputs are combinational from the current
// state and the current-cycle requests, so a stall takes effect in the
// request cycle.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   stallreq_id   decode load-use hazard (level)
//   ex_mc_start   EX starts a multi-cycle op (pulse)
//   ex_mc_cycles  stall length N for that op, clamped to MAX_MC
//   flush_req     memory-stage exception (pulse)
//   flush_pc      redirect target, sampled with flush_req
//   stall[5:0]    per-stage hold: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB(0)
//   flush         clear all pipeline registers this cycle
//   new_pc        PC load value, valid with flush
//   ex_mc_done    one-cycle pulse: EX result final
//   mc_busy       FSM is in MC_BUSY
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds perf_stall_cycles (32b)
// and perf_flush_count (16b) event counters.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int MAX_MC = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             ex_mc_done,
  output logic             mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [15:0]      perf_flush_count
`endif
);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  // EX hold also freezes everything upstream; a load-use hold stops at
  // ID/EX so that ID/EX (stall[2]=1, stall[3]=0) turns into a bubble.
  localparam logic [5:0]       StallEx = 6'b001111;
  localparam logic [5:0]       StallId = 6'b000111;
  localparam logic [CNT_W-1:0] MaxMc   = CNT_W'(MAX_MC);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             donePend_q, donePend_d;
  logic [CNT_W-1:0] ncClamped;

  // State register. donePend_q carries the deferred done pulse of an
  // N==1 operation, which finishes while the FSM already sits in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      donePend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      donePend_q <= donePend_d;
    end
  end

  // Next-state and output logic. Flush wins over everything and aborts any
  // in-flight op silently; a multi-cycle op in progress masks the decode
  // stall, and start pulses seen while busy are ignored.
  always_comb begin
    stall      = '0;
    flush      = 1'b0;
    new_pc     = '0;
    ex_mc_done = 1'b0;
    mc_busy    = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    donePend_d = 1'b0;
    ncClamped  = (ex_mc_cycles > MaxMc) ? MaxMc : ex_mc_cycles;

    if (!rst) begin
      mc_busy = (state_q == MC_BUSY);
      if (flush_req) begin
        flush   = 1'b1;
        new_pc  = flush_pc;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            ex_mc_done = donePend_q;
            if (ex_mc_start) begin
              if (ncClamped == '0) begin
                ex_mc_done = 1'b1;
              end else if (ncClamped == CntOne) begin
                stall      = StallEx;
                donePend_d = 1'b1;
              end else begin
                stall   = StallEx;
                cnt_d   = ncClamped - CntOne;
                state_d = MC_BUSY;
              end
            end else if (stallreq_id) begin
              stall = StallId;
            end
          end
          MC_BUSY: begin
            if (cnt_q != '0) begin
              stall = StallEx;
              cnt_d = cnt_q - CntOne;
            end else begin
              ex_mc_done = 1'b1;
              state_d    = IDLE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perfStall_q;
  logic [15:0] perfFlush_q;

  // Free-running event counters; they wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      perfStall_q <= '0;
      perfFlush_q <= '0;
    end else begin
      if (stall != '0) perfStall_q <= perfStall_q + 32'd1;
      if (flush)       perfFlush_q <= perfFlush_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perfStall_q;
  assign perf_flush_count  = perfFlush_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. Each stimulus cycle pushes
// its hand-computed expected outputs into a queue; a monitor on the falling
// edge pops and compares them against the DUT.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        busy;
  } outVec_t;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done;
  logic        mc_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  outVec_t expQ[$];
  string   nameQ[$];
  int      checks = 0;
  int      errors = 0;
  int      expStallCnt = 0;
  int      expFlushCnt = 0;

  localparam logic [5:0] SEX = 6'b001111;
  localparam logic [5:0] SID = 6'b000111;
  localparam logic [5:0] S0  = 6'b000000;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_mc_done   (ex_mc_done),
    .mc_busy      (mc_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic applyStimulus(input logic r, input logic sr, input logic st,
                               input logic [5:0] cyc, input logic fr,
                               input logic [31:0] fpc, input logic [5:0] eStall,
                               input logic eFlush, input logic [31:0] ePc,
                               input logic eDone, input logic eBusy,
                               input string name);
    outVec_t e;
    @(posedge clk);
    #1;
    rst          = r;
    stallreq_id  = sr;
    ex_mc_start  = st;
    ex_mc_cycles = cyc;
    flush_req    = fr;
    flush_pc     = fpc;
    e.stall = eStall;
    e.flush = eFlush;
    e.pc    = ePc;
    e.done  = eDone;
    e.busy  = eBusy;
    expQ.push_back(e);
    nameQ.push_back(name);
    if (r) begin
      expStallCnt = 0;
      expFlushCnt = 0;
    end else begin
      if (eStall != 6'd0) expStallCnt++;
      if (eFlush) expFlushCnt++;
    end
  endtask

  task automatic idleCycles(input int n, input string name);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 0, 0, name);
  endtask

  task automatic checkOutput(input outVec_t e, input string name);
    outVec_t a;
    a.stall = stall;
    a.flush = flush;
    a.pc    = new_pc;
    a.done  = ex_mc_done;
    a.busy  = mc_busy;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got stall=%b flush=%b new_pc=%h done=%b busy=%b, expected stall=%b flush=%b new_pc=%h done=%b busy=%b",
               name, a.stall, a.flush, a.pc, a.done, a.busy,
               e.stall, e.flush, e.pc, e.done, e.busy);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest entry.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front(), nameQ.pop_front());
    end
  end

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = 6'd0;
    flush_req = 1'b0; flush_pc = 32'h0;

    // Reset dominates every request.
    applyStimulus(1, 1, 1, 6'd5, 1, 32'hDEADBEEF, S0, 0, 32'h0, 0, 0, "reset0");
    applyStimulus(1, 1, 1, 6'd5, 1, 32'hDEADBEEF, S0, 0, 32'h0, 0, 0, "reset1");
    idleCycles(1, "postReset");

    // Reset in the middle of a busy op: no done pulse afterwards.
    applyStimulus(0, 0, 1, 6'd5, 0, 32'h0, SEX, 0, 32'h0, 0, 0, "rstMid_start");
    applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "rstMid_busy");
    applyStimulus(1, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 0, 0, "rstMid_reset");
    idleCycles(6, "rstMid_noDone");

    // Load-use stall for three cycles.
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 0, 6'd0, 0, 32'h0, SID, 0, 32'h0, 0, 0, "loadUse");
    idleCycles(1, "loadUse_end");

    // N=5 with a stray start (must not reload) and a masked load-use.
    applyStimulus(0, 0, 1, 6'd5, 0, 32'h0, SEX, 0, 32'h0, 0, 0, "mc5_start");
    applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "mc5_busy1");
    applyStimulus(0, 0, 1, 6'd40, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "mc5_strayStart");
    applyStimulus(0, 1, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "mc5_maskedId");
    applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "mc5_busy4");
    applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 1, 1, "mc5_done");
    idleCycles(2, "mc5_after");

    // N=0: done in the start cycle, no stall.
    applyStimulus(0, 0, 1, 6'd0, 0, 32'h0, S0, 0, 32'h0, 1, 0, "mc0_done");
    idleCycles(1, "mc0_after");

    // N=1: one stall cycle, done next cycle alongside normal arbitration.
    applyStimulus(0, 0, 1, 6'd1, 0, 32'h0, SEX, 0, 32'h0, 0, 0, "mc1_start");
    applyStimulus(0, 1, 0, 6'd0, 0, 32'h0, SID, 0, 32'h0, 1, 0, "mc1_donePend");
    idleCycles(1, "mc1_after");

    // N=2: smallest length that goes through MC_BUSY.
    applyStimulus(0, 0, 1, 6'd2, 0, 32'h0, SEX, 0, 32'h0, 0, 0, "mc2_start");
    applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "mc2_busy");
    applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 1, 1, "mc2_done");
    idleCycles(1, "mc2_after");

    // N=63 is clamped to 40 stall cycles.
    applyStimulus(0, 0, 1, 6'd63, 0, 32'h0, SEX, 0, 32'h0, 0, 0, "mc63_start");
    for (int i = 0; i < 39; i++)
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "mc63_busy");
    applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 1, 1, "mc63_done");
    idleCycles(1, "mc63_after");

    // N=10 aborted by a flush on the 4th busy cycle.
    applyStimulus(0, 0, 1, 6'd10, 0, 32'h0, SEX, 0, 32'h0, 0, 0, "abort_start");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1, "abort_busy");
    applyStimulus(0, 0, 0, 6'd0, 1, 32'hBFC00380, S0, 1, 32'hBFC00380, 0, 1, "abort_flush");
    idleCycles(12, "abort_noDone");

    // Flush, start and load-use all at once: only the flush is seen.
    applyStimulus(0, 1, 1, 6'd8, 1, 32'h00001234, S0, 1, 32'h00001234, 0, 0, "allReq_flush");
    idleCycles(3, "allReq_after");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
    end

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    checks++;
    if (perf_flush_count !== 16'(expFlushCnt)) begin
      errors++;
      $display("[TB] FAIL perfFlush: got %0d, expected %0d", perf_flush_count, expFlushCnt);
    end
    checks++;
    if (perf_stall_cycles !== 32'(expStallCnt)) begin
      errors++;
      $display("[TB] FAIL perfStall: got %0d, expected %0d", perf_stall_cycles, expStallCnt);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
